// File: rtl/song_sequencer.sv
// Song sequencer: fetches {note,duration} words from the song ROM and hands them to note_player.
// Optional build macro SONG_SEQ_LOOP_EN: replay the song from entry 0 instead of returning to IDLE.
module song_sequencer #(
  parameter int NOTE_BITS = 5,
  parameter int SONG_BITS = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play,
  input  logic [SONG_BITS-1:0]           song,
  output logic [SONG_BITS+NOTE_BITS-1:0] rom_addr,
  input  logic [11:0]                    rom_data,
  output logic [5:0]                     note_to_load,
  output logic [5:0]                     duration_to_load,
  output logic                           load_new_note,
  input  logic                           done_with_note,
  output logic                           song_done
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_ROM, LOAD, WAIT_DONE, END_S
  } state_t;

  state_t                         state_q, state_d;
  logic [NOTE_BITS-1:0]           idx_q, idx_d;
  logic [SONG_BITS-1:0]           song_q, song_d;
  logic [SONG_BITS+NOTE_BITS-1:0] addr_q, addr_d;
  logic [5:0]                     note_q, note_d;
  logic [5:0]                     dur_q, dur_d;
  logic [NOTE_BITS-1:0]           idx_inc;
  logic                           song_chg;

  assign idx_inc = idx_q + 1'b1;

  // A new song selection restarts playback except mid-IDLE and mid-LOAD
  assign song_chg = (state_q != IDLE) && (state_q != LOAD) &&
                    (song != song_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    song_d  = song_q;
    addr_d  = addr_q;
    note_d  = note_q;
    dur_d   = dur_q;
    if (song_chg) begin
      idx_d   = '0;
      song_d  = song;
      addr_d  = {song, {NOTE_BITS{1'b0}}};
      state_d = FETCH;
    end else begin
      unique case (state_q)
        IDLE: if (play) begin
          idx_d   = '0;
          song_d  = song;
          addr_d  = {song, {NOTE_BITS{1'b0}}};
          state_d = FETCH;
        end
        FETCH: if (play) state_d = WAIT_ROM;
        WAIT_ROM: if (play) begin
          if (rom_data[5:0] == 6'd0) begin
            state_d = END_S;
          end else begin
            note_d  = rom_data[11:6];
            dur_d   = rom_data[5:0];
            state_d = LOAD;
          end
        end
        LOAD: state_d = WAIT_DONE;
        // done is honoured even while paused
        WAIT_DONE: if (done_with_note) begin
          if (idx_q == {NOTE_BITS{1'b1}}) begin
            state_d = END_S;
          end else begin
            idx_d   = idx_inc;
            addr_d  = {song_q, idx_inc};
            state_d = FETCH;
          end
        end
        END_S: begin
          idx_d = '0;
`ifdef SONG_SEQ_LOOP_EN
          addr_d  = {song_q, {NOTE_BITS{1'b0}}};
          state_d = FETCH;
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      song_q  <= '0;
      addr_q  <= '0;
      note_q  <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      song_q  <= song_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
    end
  end

  assign rom_addr         = addr_q;
  assign note_to_load     = note_q;
  assign duration_to_load = dur_q;
  assign load_new_note    = (state_q == LOAD);
  assign song_done        = (state_q == END_S);

endmodule
